tlb_ctrl: RTL and testbench

- Owns the TLB entry storage and drives the global `tlb_table` bus that the TLB lookup logic reads combinationally.
- Executes the CP0 TLB instructions TLBP, TLBR, TLBWI and TLBWR, issued from the memory/writeback stage through a valid/ready handshake.
- Maintains the MIPS Random register.
- Returns probe and read results to CP0.

---
 rtl/tlb_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_tlb_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_ctrl.sv
// tlb_ctrl: TLB entry storage plus CP0 TLBP/TLBR/TLBWI/TLBWR executor and MIPS Random register.
// Latency: TLBR/TLBWI/TLBWR respond 1 cycle after accept, TLBP 2 cycles; table writes are visible the cycle after accept.
// Backpressure: op_ready is high only in IDLE, so one request is in flight at a time and no request is ever dropped.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   op_valid/op_ready       request handshake; op_code 0=TLBP 1=TLBR 2=TLBWI 3=TLBWR
//   entryhi/entrylo0/1      CP0 operand registers, sampled on the accept cycle only
//   index_in, wired_in      CP0 Index and Wired; wired_we pulses when CP0 writes Wired
//   resp_valid, resp_op     one-cycle completion pulse and the op it belongs to
//   probe_miss/probe_index  TLBP result; rd_entryhi/rd_entrylo0/1 TLBR result
//   random_out              current Random register
//   tlb_table               flat entry array for the lookup logic, entry 0 in the LSBs
module tlb_ctrl #(
  parameter int TLB_ENTRIES = 16,
  parameter int IDX_W       = $clog2(TLB_ENTRIES)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      op_valid,
  output logic                      op_ready,
  input  logic [1:0]                op_code,
  input  logic [31:0]               entryhi,
  input  logic [31:0]               entrylo0,
  input  logic [31:0]               entrylo1,
  input  logic [IDX_W-1:0]          index_in,
  input  logic [IDX_W-1:0]          wired_in,
  input  logic                      wired_we,
  output logic                      resp_valid,
  output logic [1:0]                resp_op,
  output logic                      probe_miss,
  output logic [IDX_W-1:0]          probe_index,
  output logic [31:0]               rd_entryhi,
  output logic [31:0]               rd_entrylo0,
  output logic [31:0]               rd_entrylo1,
  output logic [IDX_W-1:0]          random_out,
  output logic [TLB_ENTRIES*78-1:0] tlb_table
);

  // Field order matches the tlb_table bus layout, first field in the MSBs.
  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PROBE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  localparam logic [1:0]       OP_TLBP  = 2'd0;
  localparam logic [1:0]       OP_TLBR  = 2'd1;
  localparam logic [1:0]       OP_TLBWR = 2'd3;
  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(TLB_ENTRIES - 1);

  state_t           r_state;
  tlb_entry_t       r_tlb [TLB_ENTRIES];
  logic [IDX_W-1:0] r_random;
  logic [18:0]      r_vpn2;
  logic [7:0]       r_asid;
  logic [1:0]       r_resp_op;
  logic             r_probe_miss;
  logic [IDX_W-1:0] r_probe_index;
  logic [31:0]      r_rd_hi;
  logic [31:0]      r_rd_lo0;
  logic [31:0]      r_rd_lo1;

  logic             w_accept;
  logic [IDX_W-1:0] w_target;
  tlb_entry_t       w_new;
  tlb_entry_t       w_rd;
  logic             w_hit;
  logic [IDX_W-1:0] w_hit_idx;
  logic             w_unused;

  assign w_accept = op_valid && (r_state == S_IDLE);
  // TLBWR targets the Random value visible during the accept cycle, before any wired_we reload.
  assign w_target = (op_code == OP_TLBWR) ? r_random : index_in;
  assign w_rd     = r_tlb[index_in];

  always_comb begin
    w_new      = '0;
    w_new.vpn2 = entryhi[31:13];
    w_new.asid = entryhi[7:0];
    w_new.g    = entrylo0[0] & entrylo1[0];
    w_new.pfn0 = entrylo0[25:6];
    w_new.c0   = entrylo0[5:3];
    w_new.d0   = entrylo0[2];
    w_new.v0   = entrylo0[1];
    w_new.pfn1 = entrylo1[25:6];
    w_new.c1   = entrylo1[5:3];
    w_new.d1   = entrylo1[2];
    w_new.v1   = entrylo1[1];
  end

  // Reserved CP0 bits are architecturally ignored.
  assign w_unused = ^{entryhi[12:8], entrylo0[31:26], entrylo1[31:26]};

  // Scan downward so the lowest matching index is the one left standing.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if ((r_tlb[i].vpn2 == r_vpn2) && ((r_tlb[i].asid == r_asid) || r_tlb[i].g)) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TLB_ENTRIES; i++) begin
        r_tlb[i] <= '0;
      end
    end else if (w_accept && op_code[1]) begin
      r_tlb[w_target] <= w_new;
    end
  end

  // Zero also wraps to the top so an out-of-range Wired cannot stall the counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_random <= IDX_MAX;
    end else if (wired_we || (r_random == wired_in) || (r_random == '0)) begin
      r_random <= IDX_MAX;
    end else begin
      r_random <= r_random - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_vpn2        <= '0;
      r_asid        <= '0;
      r_resp_op     <= '0;
      r_probe_miss  <= 1'b0;
      r_probe_index <= '0;
      r_rd_hi       <= '0;
      r_rd_lo0      <= '0;
      r_rd_lo1      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (op_code == OP_TLBP) begin
              r_vpn2  <= entryhi[31:13];
              r_asid  <= entryhi[7:0];
              r_state <= S_PROBE;
            end else begin
              r_resp_op <= op_code;
              r_state   <= S_RESP;
              if (op_code == OP_TLBR) begin
                r_rd_hi  <= {w_rd.vpn2, 5'b0, w_rd.asid};
                r_rd_lo0 <= {6'b0, w_rd.pfn0, w_rd.c0, w_rd.d0, w_rd.v0, w_rd.g};
                r_rd_lo1 <= {6'b0, w_rd.pfn1, w_rd.c1, w_rd.d1, w_rd.v1, w_rd.g};
              end
            end
          end
        end
        S_PROBE: begin
          // Table cannot change here: no write is accepted while probing.
          r_probe_miss  <= ~w_hit;
          r_probe_index <= w_hit_idx;
          r_resp_op     <= OP_TLBP;
          r_state       <= S_RESP;
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < TLB_ENTRIES; gi++) begin : g_table
    assign tlb_table[gi*78 +: 78] = r_tlb[gi];
  end

  assign op_ready    = (r_state == S_IDLE);
  assign resp_valid  = (r_state == S_RESP);
  assign resp_op     = r_resp_op;
  assign probe_miss  = r_probe_miss;
  assign probe_index = r_probe_index;
  assign rd_entryhi  = r_rd_hi;
  assign rd_entrylo0 = r_rd_lo0;
  assign rd_entrylo1 = r_rd_lo1;
  assign random_out  = r_random;

endmodule

// File: tb/tb_tlb_ctrl.sv
// tb_tlb_ctrl: directed test of tlb_ctrl against an architectural model of the TLB and Random register.
// Latency: model tracks the 1-cycle (2 for TLBP) response timing and checks every cycle on the falling edge.
// Backpressure: requests are only raised when the model says the block is idle.
module tb_tlb_ctrl;

  localparam int N  = 16;
  localparam int IW = 4;
  localparam int EW = 78;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            op_valid = 1'b0;
  logic [1:0]      op_code = '0;
  logic [31:0]     entryhi = '0;
  logic [31:0]     entrylo0 = '0;
  logic [31:0]     entrylo1 = '0;
  logic [IW-1:0]   index_in = '0;
  logic [IW-1:0]   wired_in = 4'd4;
  logic            wired_we = 1'b0;

  logic            op_ready;
  logic            resp_valid;
  logic [1:0]      resp_op;
  logic            probe_miss;
  logic [IW-1:0]   probe_index;
  logic [31:0]     rd_entryhi;
  logic [31:0]     rd_entrylo0;
  logic [31:0]     rd_entrylo1;
  logic [IW-1:0]   random_out;
  logic [N*EW-1:0] tlb_table;

  tlb_ctrl #(.TLB_ENTRIES(N)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .entryhi(entryhi), .entrylo0(entrylo0), .entrylo1(entrylo1), .index_in(index_in),
    .wired_in(wired_in), .wired_we(wired_we), .resp_valid(resp_valid), .resp_op(resp_op),
    .probe_miss(probe_miss), .probe_index(probe_index), .rd_entryhi(rd_entryhi),
    .rd_entrylo0(rd_entrylo0), .rd_entrylo1(rd_entrylo1), .random_out(random_out),
    .tlb_table(tlb_table)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Architectural model: entries kept as the raw CP0 register images.
  logic [31:0] m_hi [N];
  logic [31:0] m_lo0 [N];
  logic [31:0] m_lo1 [N];
  logic        m_g [N];
  int          m_rand = N - 1;
  int          m_left = 0;   // cycles until idle; 1 means this is the response cycle
  logic [1:0]  m_rop = '0;
  logic        m_pmiss = 1'b0;
  int          m_pidx = 0;
  logic [31:0] m_rhi = '0, m_rlo0 = '0, m_rlo1 = '0;
  logic        p_miss;
  int          p_idx;

  function automatic logic [EW-1:0] pack(input int i);
    return {m_hi[i][31:13], m_hi[i][7:0], m_g[i], m_lo0[i][25:1], m_lo1[i][25:1]};
  endfunction

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int nr;
    int t;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_hi[i] = '0; m_lo0[i] = '0; m_lo1[i] = '0; m_g[i] = 1'b0;
      end
      m_rand = N - 1; m_left = 0; m_rop = '0; m_pmiss = 1'b0; m_pidx = 0;
      m_rhi = '0; m_rlo0 = '0; m_rlo1 = '0;
    end else begin
      nr = (wired_we || m_rand == int'(wired_in) || m_rand == 0) ? N - 1 : m_rand - 1;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 1) begin
          m_pmiss = p_miss; m_pidx = p_idx; m_rop = 2'd0;
        end
      end else if (op_valid) begin
        case (op_code)
          2'd0: begin
            p_miss = 1'b1; p_idx = 0;
            for (int i = 0; i < N; i++) begin
              if (p_miss && m_hi[i][31:13] == entryhi[31:13] &&
                  (m_hi[i][7:0] == entryhi[7:0] || m_g[i])) begin
                p_miss = 1'b0; p_idx = i;
              end
            end
            m_left = 2;
          end
          2'd1: begin
            t = int'(index_in);
            m_rhi  = {m_hi[t][31:13], 5'b0, m_hi[t][7:0]};
            m_rlo0 = {6'b0, m_lo0[t][25:1], m_g[t]};
            m_rlo1 = {6'b0, m_lo1[t][25:1], m_g[t]};
            m_rop = 2'd1; m_left = 1;
          end
          default: begin
            t = (op_code == 2'd2) ? int'(index_in) : m_rand;
            m_hi[t] = entryhi; m_lo0[t] = entrylo0; m_lo1[t] = entrylo1;
            m_g[t] = entrylo0[0] & entrylo1[0];
            m_rop = op_code; m_left = 1;
          end
        endcase
      end
      m_rand = nr;
    end
  endtask

  // Compare, then advance the model with the inputs that the next rising edge will sample.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        check($sformatf("table[%0d]", i), tlb_table[i*EW +: EW], pack(i));
      end
      check("random_out", EW'(random_out), EW'(m_rand));
      check("op_ready", EW'(op_ready), EW'(m_left == 0));
      check("resp_valid", EW'(resp_valid), EW'(m_left == 1));
      check("resp_op", EW'(resp_op), EW'(m_rop));
      check("probe_miss", EW'(probe_miss), EW'(m_pmiss));
      check("probe_index", EW'(probe_index), EW'(m_pidx));
      check("rd_entryhi", EW'(rd_entryhi), EW'(m_rhi));
      check("rd_entrylo0", EW'(rd_entrylo0), EW'(m_rlo0));
      check("rd_entrylo1", EW'(rd_entrylo1), EW'(m_rlo1));
    end
    model_step();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise one request when idle (and optionally when Random shows want_rand); returns in the following cycle.
  task automatic issue(input logic [1:0] code, input logic [31:0] hi, input logic [31:0] lo0,
                       input logic [31:0] lo1, input int idx, input int want_rand, input bit wwe);
    int guard;
    guard = 0;
    while (!(m_left == 0 && (want_rand < 0 || m_rand == want_rand))) begin
      tick();
      guard++;
      if (guard > 200) begin
        vectors++; miscompares++;
        $display("FAIL issue_wait: got timeout expected idle within 200 cycles");
        return;
      end
    end
    op_valid = 1'b1; op_code = code; entryhi = hi; entrylo0 = lo0; entrylo1 = lo1;
    index_in = IW'(idx); wired_we = wwe;
    tick();
    op_valid = 1'b0; wired_we = 1'b0;
    entryhi = 32'hDEAD_BEEF; entrylo0 = 32'hFFFF_FFFF; entrylo1 = 32'hFFFF_FFFF; index_in = '1;
  endtask

  logic [EW-1:0] lit;
  int            guard;

  initial begin
    tick();
    chk_en = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Random from reset with Wired=4: 15 down to 4, then wraps to 15.
    for (int k = 0; k < 16; k++) begin
      #2;
      check("random_seq", EW'(random_out), EW'((k < 12) ? 15 - k : 27 - k));
      @(posedge clk); #1;
    end

    // wired_we pulse while Random shows 9.
    guard = 0;
    while (m_rand != 9 && guard < 40) begin tick(); guard++; end
    check("random_at_9", EW'(random_out), EW'(9));
    wired_we = 1'b1;
    tick();
    wired_we = 1'b0;
    #2;
    check("random_after_wired_we", EW'(random_out), EW'(15));
    tick();

    // TLBWI entry 3.
    issue(2'd2, 32'h1234_6005, 32'h0004_0017, 32'h0004_001F, 3, -1, 1'b0);
    #2;
    lit = {19'h091A3, 8'h05, 1'b1, 20'h01000, 3'd2, 1'b1, 1'b1, 20'h01000, 3'd3, 1'b1, 1'b1};
    check("tlbwi_entry3", tlb_table[3*EW +: EW], lit);
    check("tlbwi_resp", EW'(resp_valid), EW'(1));
    tick();

    // TLBP: global hit despite ASID mismatch.
    issue(2'd0, 32'h1234_7077, '0, '0, 0, -1, 1'b0);
    #2;
    check("tlbp_not_yet", EW'(resp_valid), EW'(0));
    tick();
    #2;
    check("tlbp_g_resp", EW'(resp_valid), EW'(1));
    check("tlbp_g_miss", EW'(probe_miss), EW'(0));
    check("tlbp_g_index", EW'(probe_index), EW'(3));
    tick();

    // TLBP miss.
    issue(2'd0, 32'h0000_2005, '0, '0, 0, -1, 1'b0);
    tick();
    #2;
    check("tlbp_miss", EW'(probe_miss), EW'(1));
    check("tlbp_miss_index", EW'(probe_index), EW'(0));
    tick();

    // TLBR entry 3 reconstructs the written registers.
    issue(2'd1, '0, '0, '0, 3, -1, 1'b0);
    #2;
    check("tlbr_hi", EW'(rd_entryhi), EW'(32'h1234_6005));
    check("tlbr_lo0", EW'(rd_entrylo0), EW'(32'h0004_0017));
    check("tlbr_lo1", EW'(rd_entrylo1), EW'(32'h0004_001F));
    tick();

    // TLBWR at Random=7 in the same cycle as wired_we.
    issue(2'd3, 32'h0ABC_E042, 32'h0012_3457, 32'h00AB_CD06, 0, 7, 1'b1);
    #2;
    check("tlbwr_random", EW'(random_out), EW'(15));
    check("tlbwr_vpn2", EW'(tlb_table[7*EW + 59 +: 19]), EW'(19'h055E7));
    check("tlbwr_g", EW'(tlb_table[7*EW + 50]), EW'(0));
    tick();

    // Duplicate entries 5 and 2; probe picks the lowest.
    issue(2'd2, 32'h5555_4033, 32'h0004_0003, 32'h0008_0002, 5, -1, 1'b0);
    issue(2'd2, 32'h5555_4033, 32'h0004_0003, 32'h0008_0002, 2, -1, 1'b0);
    issue(2'd0, 32'h5555_4033, '0, '0, 0, -1, 1'b0);
    tick();
    #2;
    check("dup_index", EW'(probe_index), EW'(2));
    check("dup_miss", EW'(probe_miss), EW'(0));
    tick();

    // Reset during PROBE.
    issue(2'd0, 32'h5555_4033, '0, '0, 0, -1, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #2;
    check("rst_resp_valid", EW'(resp_valid), EW'(0));
    check("rst_op_ready", EW'(op_ready), EW'(1));
    for (int i = 0; i < N; i++) begin
      check($sformatf("rst_entry[%0d]", i), tlb_table[i*EW +: EW], '0);
    end
    tick();
    tick();

    // Write accepted in a reset cycle is discarded.
    reset = 1'b1; op_valid = 1'b1; op_code = 2'd2; index_in = 4'd1;
    entryhi = 32'h1234_6005; entrylo0 = 32'h0004_0017; entrylo1 = 32'h0004_001F;
    tick();
    reset = 1'b0; op_valid = 1'b0;
    #2;
    check("rst_write_dropped", tlb_table[1*EW +: EW], '0);
    tick();

    // Post-reset operation resumes.
    issue(2'd2, 32'hFFFF_E0AA, 32'h03FF_FFFF, 32'h0000_0001, 15, -1, 1'b0);
    issue(2'd1, '0, '0, '0, 15, -1, 1'b0);
    #2;
    check("post_rst_hi", EW'(rd_entryhi), EW'(32'hFFFF_E0AA));
    check("post_rst_lo0", EW'(rd_entrylo0), EW'(32'h03FF_FFFF));
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
